// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, fetches over a single-outstanding req/ack port.
// Optional macro FETCH_PERF_EN builds a saturating StallCount of fetch bubbles; otherwise StallCount is 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        IFIDFlush,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_Instr,
  output logic        IFID_Valid,
  output logic        FetchStall,
  output logic [31:0] StallCount,
  output logic [1:0]  dbg_state
);

  // Handshake: imem_req/imem_addr hold steady from the cycle req rises until the cycle imem_ack=1;
  // imem_rdata is taken only in a cycle where imem_req & imem_ack are both 1.

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        run;
  logic        adv;
  logic [31:0] pc, pc_nxt, pc_plus4, target_al;
  logic [31:0] old_pc, old_pc_nxt;
  logic [31:0] buffer, buffer_nxt;
  logic [31:0] pc4_nxt, instr_nxt;
  logic        valid_nxt;
  logic        unused_target_bits;

  assign adv                = PCWrite & IFIDWrite;
  assign pc_plus4           = pc + 32'd4;
  assign target_al          = {BranchTarget[31:2], 2'b00};
  assign unused_target_bits = ^BranchTarget[1:0];
  assign dbg_state          = state;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    old_pc_nxt = old_pc;
    buffer_nxt = buffer;
    pc4_nxt    = IFID_PC4;
    instr_nxt  = IFID_Instr;
    valid_nxt  = IFID_Valid;
    imem_req   = 1'b0;
    imem_addr  = pc;
    FetchStall = 1'b0;

    case (state)
      S_FETCH:   imem_req = run;
      S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = old_pc;
      end
      default:   imem_req = 1'b0;
    endcase

    if (IFIDFlush) begin
      instr_nxt = NOP_INSTR;
      valid_nxt = 1'b0;
      pc_nxt    = target_al;
      // An unanswered request must stay on the bus, so remember its address and wait it out.
      if (imem_req && !imem_ack) begin
        state_nxt  = S_DISCARD;
        old_pc_nxt = imem_addr;
      end else begin
        state_nxt = S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (run) begin
            if (imem_ack && adv) begin
              pc4_nxt   = pc_plus4;
              instr_nxt = imem_rdata;
              valid_nxt = 1'b1;
              pc_nxt    = pc_plus4;
            end else if (imem_ack) begin
              buffer_nxt = imem_rdata;
              state_nxt  = S_HOLD;
            end else if (adv) begin
              instr_nxt  = NOP_INSTR;
              valid_nxt  = 1'b0;
              FetchStall = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (adv) begin
            pc4_nxt   = pc_plus4;
            instr_nxt = buffer;
            valid_nxt = 1'b1;
            pc_nxt    = pc_plus4;
            state_nxt = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (adv) begin
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
          end
          if (imem_ack) state_nxt = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  // run keeps imem_req low until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      run        <= 1'b0;
      pc         <= RESET_PC;
      old_pc     <= 32'd0;
      buffer     <= 32'd0;
      IFID_PC4   <= 32'd0;
      IFID_Instr <= NOP_INSTR;
      IFID_Valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      run        <= 1'b1;
      pc         <= pc_nxt;
      old_pc     <= old_pc_nxt;
      buffer     <= buffer_nxt;
      IFID_PC4   <= pc4_nxt;
      IFID_Instr <= instr_nxt;
      IFID_Valid <= valid_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 32'd0;
    end else if (FetchStall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  assign StallCount = stall_count;
`else
  assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/flush/latency traffic
// checked against an instruction-stream model of program order.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0BAD_0000;

  logic        clk, reset;
  logic        PCWrite, IFIDWrite, IFIDFlush;
  logic [31:0] BranchTarget;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IFID_PC4, IFID_Instr, StallCount;
  logic        IFID_Valid, FetchStall;
  logic [1:0]  dbg_state;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .BranchTarget(BranchTarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IFID_PC4(IFID_PC4), .IFID_Instr(IFID_Instr), .IFID_Valid(IFID_Valid),
    .FetchStall(FetchStall), .StallCount(StallCount), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream model: exp_pc is the next program-order PC that must enter IF/ID.
  int          n_cmp = 0;
  int          n_err = 0;
  int          stall_exp = 0;
  int          loads = 0;
  logic        holding, stale, prev_pend;
  logic [31:0] exp_pc, prev_addr, last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_00C3) * 32'h0101_0107 + 32'h1357_9BDF;
  endfunction

  task automatic cycle(input logic pw, input logic iw, input logic fl,
                       input logic [31:0] tgt, input logic ack_en);
    logic        adv, req, ack, avail, exp_fs;
    logic [31:0] addr, p_pc4, p_instr, exp_sc;
    logic        p_valid;
    PCWrite = pw; IFIDWrite = iw; IFIDFlush = fl; BranchTarget = tgt;
    #1;
    req = imem_req; addr = imem_addr; ack = req & ack_en;
    imem_ack = ack;
    imem_rdata = ack ? mem_word(addr) : $urandom;
    #1;
    adv = pw & iw;
    last_addr = addr;
    n_cmp++;
    if (req !== !holding) begin
      n_err++; $display("FAIL req_vs_hold: imem_req=%b expected %b", req, !holding);
    end
    if (prev_pend) begin
      n_cmp++;
      if (req !== 1'b1 || addr !== prev_addr) begin
        n_err++; $display("FAIL req_stable: req=%b addr=%h expected req=1 addr=%h", req, addr, prev_addr);
      end
    end
    if (req && !stale) begin
      n_cmp++;
      if (addr !== exp_pc) begin
        n_err++; $display("FAIL fetch_addr: addr=%h expected %h", addr, exp_pc);
      end
    end
    exp_fs = req & !ack & adv & !fl & !stale;
    n_cmp++;
    if (FetchStall !== exp_fs) begin
      n_err++; $display("FAIL fetch_stall: got %b expected %b", FetchStall, exp_fs);
    end
    if (exp_fs) stall_exp++;
    p_pc4 = IFID_PC4; p_instr = IFID_Instr; p_valid = IFID_Valid;
    avail = holding | (ack & !stale);
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (fl) begin
      n_cmp++;
      if (IFID_Valid !== 1'b0 || IFID_Instr !== NOP_INSTR || IFID_PC4 !== p_pc4) begin
        n_err++; $display("FAIL flush_bubble: v=%b i=%h pc4=%h expected v=0 i=%h pc4=%h",
                          IFID_Valid, IFID_Instr, IFID_PC4, NOP_INSTR, p_pc4);
      end
      holding = 1'b0;
      stale = req & !ack;
      exp_pc = {tgt[31:2], 2'b00};
    end else begin
      if (adv) begin
        n_cmp++;
        if (IFID_Valid !== avail) begin
          n_err++; $display("FAIL ifid_valid: got %b expected %b", IFID_Valid, avail);
        end else if (avail) begin
          n_cmp++;
          if (IFID_PC4 !== exp_pc + 32'd4 || IFID_Instr !== mem_word(exp_pc)) begin
            n_err++; $display("FAIL ifid_instr: pc4=%h i=%h expected pc4=%h i=%h",
                              IFID_PC4, IFID_Instr, exp_pc + 32'd4, mem_word(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
          loads++;
        end else begin
          n_cmp++;
          if (IFID_Instr !== NOP_INSTR || IFID_PC4 !== p_pc4) begin
            n_err++; $display("FAIL ifid_bubble: i=%h pc4=%h expected i=%h pc4=%h",
                              IFID_Instr, IFID_PC4, NOP_INSTR, p_pc4);
          end
        end
        holding = 1'b0;
      end else begin
        n_cmp++;
        if (IFID_Valid !== p_valid || IFID_Instr !== p_instr || IFID_PC4 !== p_pc4) begin
          n_err++; $display("FAIL ifid_hold: v=%b i=%h pc4=%h expected v=%b i=%h pc4=%h",
                            IFID_Valid, IFID_Instr, IFID_PC4, p_valid, p_instr, p_pc4);
        end
        if (ack && !stale) holding = 1'b1;
      end
      if (ack) stale = 1'b0;
    end
    prev_pend = req & !ack;
    prev_addr = addr;
`ifdef FETCH_PERF_EN
    exp_sc = stall_exp;
`else
    exp_sc = 32'd0;
`endif
    n_cmp++;
    if (StallCount !== exp_sc) begin
      n_err++; $display("FAIL stall_count: got %0d expected %0d", StallCount, exp_sc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; PCWrite = 1'b0; IFIDWrite = 1'b0; IFIDFlush = 1'b0;
    BranchTarget = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
    #2;
    n_cmp++;
    if (imem_req !== 1'b0 || IFID_PC4 !== 32'd0 || IFID_Instr !== NOP_INSTR || IFID_Valid !== 1'b0 ||
        FetchStall !== 1'b0 || StallCount !== 32'd0) begin
      n_err++; $display("FAIL reset_values: req=%b pc4=%h i=%h v=%b fs=%b sc=%h",
                        imem_req, IFID_PC4, IFID_Instr, IFID_Valid, FetchStall, StallCount);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL req_after_release: got %b expected 0", imem_req);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_err++; $display("FAIL first_req: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
    holding = 1'b0; stale = 1'b0; prev_pend = 1'b0; exp_pc = RESET_PC;
  endtask

  task automatic test_zero_wait();
    for (int i = 1; i <= 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      n_cmp++;
      if (IFID_PC4 !== 32'(4 * i) || IFID_Instr !== mem_word(32'(4 * (i - 1))) || IFID_Valid !== 1'b1) begin
        n_err++; $display("FAIL zero_wait_%0d: pc4=%h i=%h v=%b expected pc4=%h", i, IFID_PC4,
                          IFID_Instr, IFID_Valid, 32'(4 * i));
      end
    end
  endtask

  task automatic test_load_use();
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (imem_req !== 1'b0 || IFID_PC4 !== 32'd8) begin
      n_err++; $display("FAIL load_use_hold: req=%b pc4=%h expected req=0 pc4=8", imem_req, IFID_PC4);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (IFID_Instr !== mem_word(32'd8) || IFID_PC4 !== 32'd12 || IFID_Valid !== 1'b1) begin
      n_err++; $display("FAIL load_use_release: i=%h pc4=%h expected i=%h pc4=c", IFID_Instr,
                        IFID_PC4, mem_word(32'd8));
    end
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_mem_wait();
    logic [31:0] exp_sc;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      n_cmp++;
      if (IFID_Valid !== 1'b0 || IFID_Instr !== NOP_INSTR) begin
        n_err++; $display("FAIL mem_wait_bubble: v=%b i=%h expected v=0 i=%h", IFID_Valid, IFID_Instr, NOP_INSTR);
      end
    end
`ifdef FETCH_PERF_EN
    exp_sc = 32'd3;
`else
    exp_sc = 32'd0;
`endif
    n_cmp++;
    if (StallCount !== exp_sc) begin
      n_err++; $display("FAIL mem_wait_count: got %0d expected %0d", StallCount, exp_sc);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (IFID_PC4 !== 32'h14 || IFID_Instr !== mem_word(32'h10)) begin
      n_err++; $display("FAIL mem_wait_data: pc4=%h i=%h expected pc4=14", IFID_PC4, IFID_Instr);
    end
  endtask

  task automatic test_flush_pending();
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    n_cmp++;
    if (last_addr !== 32'h14) begin
      n_err++; $display("FAIL discard_addr: got %h expected 14", last_addr);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (imem_addr !== 32'h40 || IFID_Valid !== 1'b0) begin
      n_err++; $display("FAIL redirect_addr: addr=%h v=%b expected 40 0", imem_addr, IFID_Valid);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (IFID_PC4 !== 32'h44 || IFID_Instr !== mem_word(32'h40)) begin
      n_err++; $display("FAIL redirect_data: pc4=%h i=%h expected pc4=44", IFID_PC4, IFID_Instr);
    end
  endtask

  task automatic test_flush_ack();
    cycle(1'b1, 1'b1, 1'b1, 32'h80, 1'b1);
    n_cmp++;
    if (imem_addr !== 32'h80 || IFID_Valid !== 1'b0 || IFID_Instr !== NOP_INSTR) begin
      n_err++; $display("FAIL flush_ack: addr=%h v=%b i=%h expected 80 0 %h", imem_addr, IFID_Valid,
                        IFID_Instr, NOP_INSTR);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    n_cmp++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_align: addr=%h expected fffffffc", imem_addr);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (IFID_PC4 !== 32'd0 || imem_addr !== 32'd0 || IFID_Valid !== 1'b1) begin
      n_err++; $display("FAIL wrap: pc4=%h addr=%h v=%b expected 0 0 1", IFID_PC4, imem_addr, IFID_Valid);
    end
  endtask

  task automatic test_random();
    int base;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 15) == 0,
            $urandom, $urandom_range(0, 2) != 0);
    end
    base = loads;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (loads - base < 3) begin
      n_err++; $display("FAIL drain_progress: loaded %0d expected at least 3", loads - base);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_load_use();
    test_mem_wait();
    test_flush_pending();
    test_flush_ack();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
